spi_target_to_streams: RTL

SPI target (mode 0, MSB first) front end that converts SPI transactions into the byte-stream and `busy` signals consumed by the downstream `streams1_to_apb` bridge. It returns that bridge's read-data stream on MISO. SCK, CSn and MOSI are sampled into the CLK domain; no logic runs on SCK. It sits between the chip pins and the APB bridge, with `busy` tracking chip-select.

---
 rtl/spi_target_pkg.sv | 26 ++
 rtl/sync_edge_detect.sv | 42 ++++
 rtl/spi_target_to_streams.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_target_pkg.sv
// ---------------------------------------------------------------------------
// spi_target_pkg
// Shared constants for the SPI-target-to-streams front end: state encoding,
// byte and bit-counter widths, and a small shift helper.
// ---------------------------------------------------------------------------
package spi_target_pkg;

    localparam int BYTE_BITS = 8;
    localparam int BIT_CNT_W = 3;

    // Last bit index of a byte; the counter wraps to zero after it.
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = 3'd7;

    // Transaction state encoding.
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Shift one bit into the LSB end (MSB-first serial order).
    function automatic logic [BYTE_BITS-1:0] shift_in_lsb(
        input logic [BYTE_BITS-1:0] cur,
        input logic                 bit_in
    );
        return {cur[BYTE_BITS-2:0], bit_in};
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// N-flop synchronizer for one asynchronous input with single-cycle rise and
// fall pulses derived from the synchronized level.
// Ports:
//   CLK, RESET : system clock, synchronous active-high reset
//   async_in   : asynchronous input pin
//   level      : synchronized level (last synchronizer flop)
//   rise, fall : one-cycle pulses on synchronized transitions
// All flops reset to 0, so a pin that is already high when RESET releases
// produces a rise pulse once it has propagated through the synchronizer.
// ---------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Synchronizer chain plus one delayed copy of the level for edge detection.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], async_in};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign level = sync_r[STAGES-1];
    assign rise  = sync_r[STAGES-1] & ~prev_r;
    assign fall  = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_target_to_streams.sv
// ---------------------------------------------------------------------------
// spi_target_to_streams
// SPI target (mode 0, MSB first) sampled entirely in the CLK domain. Received
// bytes are presented on a valid/ready stream; read bytes are pulled from a
// valid/ready stream and shifted out on MISO. busy follows chip select.
// Ports:
//   CLK, RESET            : system clock, synchronous active-high reset
//   SCK, CSn, MOSI        : asynchronous SPI pins (SCK idles low)
//   MISO, MISO_OE         : serial data out and its pad enable
//   out_data/valid/ready  : received-byte stream towards the bridge
//   in_data/valid/ready   : read-byte stream from the bridge
//   busy                  : a transaction is active
//   overrun               : sticky, a received byte was dropped
// Configuration macro: SPI_TARGET_OVERRUN_EN builds the sticky overrun flag;
// without it overrun is tied low (colliding bytes are still dropped).
// Pipeline: synchronizer (SYNC_STAGES) -> control stage (state, counters,
// load/shift requests) -> output stage (stream register, tx shifter, busy).
// ---------------------------------------------------------------------------
module spi_target_to_streams
    import spi_target_pkg::*;
#(
    parameter int                   SYNC_STAGES = 2,
    parameter logic [BYTE_BITS-1:0] FILL_BYTE   = 8'h00
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 SCK,
    input  logic                 CSn,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic                 MISO_OE,
    output logic [BYTE_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic [BYTE_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 overrun
);

    logic sck_level_unused_s, sck_rise_s, sck_fall_s;
    logic csn_level_s, csn_rise_s, csn_fall_s;
    logic mosi_level_s, mosi_rise_unused_s, mosi_fall_unused_s;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .CLK      (CLK),
        .RESET    (RESET),
        .async_in (SCK),
        .level    (sck_level_unused_s),
        .rise     (sck_rise_s),
        .fall     (sck_fall_s)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_csn (
        .CLK      (CLK),
        .RESET    (RESET),
        .async_in (CSn),
        .level    (csn_level_s),
        .rise     (csn_rise_s),
        .fall     (csn_fall_s)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .CLK      (CLK),
        .RESET    (RESET),
        .async_in (MOSI),
        .level    (mosi_level_s),
        .rise     (mosi_rise_unused_s),
        .fall     (mosi_fall_unused_s)
    );

    // Control stage registers
    logic [0:0]           state_r;
    logic                 armed_r;
    logic [BIT_CNT_W-1:0] bit_cnt_r;
    logic [BYTE_BITS-1:0] rx_shift_r;
    logic                 byte_seen_r;
    logic                 byte_done_r;
    logic                 tx_load_r;
    logic                 tx_shift_req_r;
    logic                 in_ready_r;

    // Control stage next values
    logic [0:0]           state_s;
    logic [BIT_CNT_W-1:0] bit_cnt_s;
    logic [BYTE_BITS-1:0] rx_shift_s;
    logic                 byte_seen_s;
    logic                 byte_done_s;
    logic                 tx_load_s;
    logic                 tx_shift_req_s;

    // Output stage registers
    logic [BYTE_BITS-1:0] out_data_r;
    logic                 out_valid_r;
    logic [BYTE_BITS-1:0] tx_shift_r;
    logic                 busy_r;
    logic                 miso_oe_r;

    // Next-state logic for the transaction FSM, receive shifter and tx requests.
    always_comb begin
        state_s        = state_r;
        bit_cnt_s      = bit_cnt_r;
        rx_shift_s     = rx_shift_r;
        byte_seen_s    = byte_seen_r;
        byte_done_s    = 1'b0;
        tx_load_s      = 1'b0;
        tx_shift_req_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Entry requires CSn to have been seen high since reset, so a
                // transaction already running at reset release is ignored.
                if (csn_fall_s && armed_r) begin
                    state_s     = ST_ACTIVE;
                    bit_cnt_s   = '0;
                    rx_shift_s  = '0;
                    byte_seen_s = 1'b0;
                    tx_load_s   = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (csn_rise_s) begin
                    // Abort: any partial byte is discarded.
                    state_s     = ST_IDLE;
                    bit_cnt_s   = '0;
                    rx_shift_s  = '0;
                    byte_seen_s = 1'b0;
                end else if (sck_rise_s) begin
                    rx_shift_s = shift_in_lsb(rx_shift_r, mosi_level_s);
                    bit_cnt_s  = bit_cnt_r + BIT_CNT_W'(1);
                    if (bit_cnt_r == BIT_CNT_LAST) begin
                        byte_done_s = 1'b1;
                        byte_seen_s = 1'b1;
                    end else begin
                        byte_done_s = 1'b0;
                    end
                end else if (sck_fall_s) begin
                    // The fall after the 8th rise starts the next tx byte.
                    if ((bit_cnt_r == '0) && byte_seen_r) begin
                        tx_load_s = 1'b1;
                    end else begin
                        tx_shift_req_s = 1'b1;
                    end
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control stage state; in_ready is raised for the cycle the tx load happens.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r        <= ST_IDLE;
            armed_r        <= 1'b0;
            bit_cnt_r      <= '0;
            rx_shift_r     <= '0;
            byte_seen_r    <= 1'b0;
            byte_done_r    <= 1'b0;
            tx_load_r      <= 1'b0;
            tx_shift_req_r <= 1'b0;
            in_ready_r     <= 1'b0;
        end else begin
            state_r        <= state_s;
            armed_r        <= armed_r | csn_level_s;
            bit_cnt_r      <= bit_cnt_s;
            rx_shift_r     <= rx_shift_s;
            byte_seen_r    <= byte_seen_s;
            byte_done_r    <= byte_done_s;
            tx_load_r      <= tx_load_s;
            tx_shift_req_r <= tx_shift_req_s;
            in_ready_r     <= tx_load_s & in_valid;
        end
    end

    // Received-byte stream register; a byte arriving while the previous one is
    // still held and not being accepted this cycle is dropped.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else if (byte_done_r && (!out_valid_r || out_ready)) begin
            out_data_r  <= rx_shift_r;
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Transmit shifter plus busy/pad-enable, all one stage behind the FSM.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_shift_r <= '0;
            busy_r     <= 1'b0;
            miso_oe_r  <= 1'b0;
        end else begin
            busy_r    <= (state_r == ST_ACTIVE);
            miso_oe_r <= (state_r == ST_ACTIVE);
            if (tx_load_r) begin
                tx_shift_r <= (in_ready_r && in_valid) ? in_data : FILL_BYTE;
            end else if (tx_shift_req_r) begin
                tx_shift_r <= {tx_shift_r[BYTE_BITS-2:0], 1'b0};
            end else begin
                tx_shift_r <= tx_shift_r;
            end
        end
    end

`ifdef SPI_TARGET_OVERRUN_EN
    logic overrun_r;

    // Sticky drop indicator, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            overrun_r <= 1'b0;
        end else if (byte_done_r && out_valid_r && !out_ready) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign overrun = overrun_r;
`else
    assign overrun = 1'b0;
`endif

    assign MISO      = tx_shift_r[BYTE_BITS-1];
    assign MISO_OE   = miso_oe_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign in_ready  = in_ready_r;
    assign busy      = busy_r;

endmodule
